// File: rtl/frame_reader.sv
// Streams a captured RAM frame as 16-bit words: HEADER, count, data halfwords, optional checksum.
// Latency: HEADER is presented one edge after START; each data word needs 3 edges to fetch and capture.
// Backpressure: TX_DATA/TX_VALID hold while TX_READY is low. Define FRAME_READER_CHECKSUM_EN to append the checksum word.
module frame_reader #(
    parameter logic [15:0] HEADER    = 16'hA55A,
    parameter int          MAX_WORDS = 512
) (
    input  logic        CLOCK_10M,
    input  logic        RESET_N,
    input  logic        START,
    input  logic [9:0]  COUNT,
    input  logic        RECV_BUSY,
    output logic [9:0]  ADDR,
    input  logic [31:0] RD_DATA,
    output logic [15:0] TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_READY,
    output logic        BUSY,
    output logic        DONE
);

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_HDR    = 4'd1;
    localparam logic [3:0] ST_CNT    = 4'd2;
    localparam logic [3:0] ST_FETCH  = 4'd3;
    localparam logic [3:0] ST_WAIT   = 4'd4;
    localparam logic [3:0] ST_LO     = 4'd5;
    localparam logic [3:0] ST_HI     = 4'd6;
`ifdef FRAME_READER_CHECKSUM_EN
    localparam logic [3:0] ST_SUM    = 4'd7;
`endif
    localparam logic [3:0] ST_FINISH = 4'd8;

    localparam logic [9:0] MAX_W = 10'(MAX_WORDS);

    logic [3:0]  state_q, state_d;
    logic [9:0]  addr_q, addr_d;
    logic [15:0] tx_dat_q, tx_dat_d;
    logic        tx_vld_q, tx_vld_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [9:0]  idx_q, idx_d;
    // Upper halfword of the fetched RAM word, sent after the lower half.
    logic [15:0] hold_q, hold_d;
`ifdef FRAME_READER_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;
`endif

    logic        xfer;
    logic [9:0]  cnt_clamped;
    logic [9:0]  idx_next;

    assign xfer        = tx_vld_q & TX_READY;
    assign cnt_clamped = (COUNT > MAX_W) ? MAX_W : COUNT;
    assign idx_next    = idx_q + 10'd1;

    // Next-state and datapath: the output word only changes on a transfer or when a new word is loaded.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        tx_dat_d = tx_dat_q;
        tx_vld_d = tx_vld_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        hold_d   = hold_q;
`ifdef FRAME_READER_CHECKSUM_EN
        sum_d    = sum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (START && !RECV_BUSY) begin
                    cnt_d    = cnt_clamped;
                    idx_d    = 10'd0;
                    busy_d   = 1'b1;
                    tx_dat_d = HEADER;
                    tx_vld_d = 1'b1;
`ifdef FRAME_READER_CHECKSUM_EN
                    sum_d    = 16'd0;
`endif
                    state_d  = ST_HDR;
                end
            end
            ST_HDR: begin
                if (xfer) begin
                    tx_dat_d = {6'd0, cnt_q};
                    state_d  = ST_CNT;
                end
            end
            ST_CNT: begin
                if (xfer) begin
                    if (cnt_q == 10'd0) begin
`ifdef FRAME_READER_CHECKSUM_EN
                        // Empty frame: checksum of no halfwords is zero.
                        tx_dat_d = 16'd0;
                        state_d  = ST_SUM;
`else
                        tx_vld_d = 1'b0;
                        done_d   = 1'b1;
                        state_d  = ST_FINISH;
`endif
                    end else begin
                        tx_vld_d = 1'b0;
                        addr_d   = idx_q;
                        state_d  = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                // ADDR is stable now; the RAM samples it on this edge.
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // RD_DATA reflects ADDR from the previous edge; capture it here.
                hold_d   = RD_DATA[31:16];
                tx_dat_d = RD_DATA[15:0];
                tx_vld_d = 1'b1;
                state_d  = ST_LO;
            end
            ST_LO: begin
                if (xfer) begin
`ifdef FRAME_READER_CHECKSUM_EN
                    sum_d    = sum_q + tx_dat_q;
`endif
                    tx_dat_d = hold_q;
                    state_d  = ST_HI;
                end
            end
            ST_HI: begin
                if (xfer) begin
`ifdef FRAME_READER_CHECKSUM_EN
                    sum_d = sum_q + tx_dat_q;
`endif
                    idx_d = idx_next;
                    if (idx_next < cnt_q) begin
                        tx_vld_d = 1'b0;
                        addr_d   = idx_next;
                        state_d  = ST_FETCH;
                    end else begin
`ifdef FRAME_READER_CHECKSUM_EN
                        tx_dat_d = sum_q + tx_dat_q;
                        state_d  = ST_SUM;
`else
                        tx_vld_d = 1'b0;
                        done_d   = 1'b1;
                        state_d  = ST_FINISH;
`endif
                    end
                end
            end
`ifdef FRAME_READER_CHECKSUM_EN
            ST_SUM: begin
                if (xfer) begin
                    tx_vld_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = ST_FINISH;
                end
            end
`endif
            ST_FINISH: begin
                // DONE is high for exactly this cycle; BUSY drops on the way out.
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                tx_vld_d = 1'b0;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any frame in flight without a DONE.
    always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= ST_IDLE;
            addr_q   <= 10'd0;
            tx_dat_q <= 16'd0;
            tx_vld_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= 10'd0;
            idx_q    <= 10'd0;
            hold_q   <= 16'd0;
`ifdef FRAME_READER_CHECKSUM_EN
            sum_q    <= 16'd0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            tx_dat_q <= tx_dat_d;
            tx_vld_q <= tx_vld_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            hold_q   <= hold_d;
`ifdef FRAME_READER_CHECKSUM_EN
            sum_q    <= sum_d;
`endif
        end
    end

    assign ADDR     = addr_q;
    assign TX_DATA  = tx_dat_q;
    assign TX_VALID = tx_vld_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;

endmodule

// File: tb/tb_frame_reader.sv
// Directed bench for frame_reader: RAM model with one-cycle read latency, stream monitor, hand-computed frames.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Adapts the expected frames to whether FRAME_READER_CHECKSUM_EN is defined.
module tb_frame_reader;

`ifdef FRAME_READER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  count;
    logic        recv_busy;
    logic [9:0]  addr;
    logic [31:0] rd_data;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;
    logic        rdy_mode;

    always #50 clk = ~clk;

    frame_reader dut (
        .CLOCK_10M (clk),
        .RESET_N   (rst_n),
        .START     (start),
        .COUNT     (count),
        .RECV_BUSY (recv_busy),
        .ADDR      (addr),
        .RD_DATA   (rd_data),
        .TX_DATA   (tx_data),
        .TX_VALID  (tx_valid),
        .TX_READY  (tx_ready),
        .BUSY      (busy),
        .DONE      (done)
    );

    // Capture RAM: word i = {2i+2, 2i+1}, so RAM[0]=0002_0001, RAM[1]=0004_0003.
    logic [31:0] ram [0:1023];
    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = {16'(2 * i + 2), 16'(2 * i + 1)};
    end
    always @(posedge clk) rd_data <= ram[addr];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        if (obs !== req) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, req);
        end
    endtask

    // Ready driver: constant high, or toggling every cycle.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = rdy_mode ? ~tx_ready : 1'b1;
        end
    end

    // Stream monitor: logs transfers, DONE pulses, address activity and hold stability.
    logic [15:0] got_q[$];
    int          done_cnt = 0;
    int          addr_chg = 0;
    int          seq_err  = 0;
    int          addr_max = 0;
    logic [9:0]  prev_addr = 10'd0;
    logic        prev_vld  = 1'b0;
    logic        prev_rdy  = 1'b0;
    logic [15:0] prev_dat  = 16'd0;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (prev_vld && !prev_rdy) begin
                chk("hold_vld", 32'(tx_valid), 32'd1);
                chk("hold_dat", 32'(tx_data), 32'(prev_dat));
            end
            if (tx_valid && tx_ready) got_q.push_back(tx_data);
            if (done) done_cnt++;
        end
        if (addr != prev_addr) begin
            addr_chg++;
            if (addr != 10'd0 && addr != prev_addr + 10'd1) seq_err++;
        end
        if (int'(addr) > addr_max) addr_max = int'(addr);
        prev_addr = addr;
        prev_vld  = tx_valid;
        prev_rdy  = tx_ready;
        prev_dat  = tx_data;
    end

    // Issue START (COUNT=c), wait for BUSY to fall within budget; optionally poke START/RECV_BUSY mid-frame.
    task automatic run_frame(input logic [9:0] c, input int budget, input int poke,
                             output int base, output int cycles);
        int d0;
        base = got_q.size();
        d0   = done_cnt;
        @(posedge clk); #1;
        start = 1'b1;
        count = c;
        @(posedge clk); #1;
        start = 1'b0;
        count = 10'd0;
        chk("busy_rise", 32'(busy), 32'd1);
        cycles = 1;
        while (busy && cycles < budget) begin
            start     = (poke > 0) && (cycles == poke);
            count     = start ? 10'd5 : 10'd0;
            recv_busy = (poke > 0) && (cycles >= poke + 2);
            @(posedge clk); #1;
            cycles++;
        end
        start     = 1'b0;
        recv_busy = 1'b0;
        chk("frame_end", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("done_once", 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic cmp_words(input string tag, input int base, input logic [15:0] w[$]);
        chk({tag, "_len"}, 32'(got_q.size() - base), 32'(w.size()));
        for (int i = 0; i < w.size(); i++) begin
            if (base + i < got_q.size())
                chk($sformatf("%s[%0d]", tag, i), 32'(got_q[base + i]), 32'(w[i]));
        end
    endtask

    initial begin
        logic [15:0] e2[$];
        logic [15:0] e0[$];
        logic [15:0] eb[$];
        int base, cyc0, cyc1, cyc2, a0, chg0, d0, guard;

        rst_n     = 1'b0;
        start     = 1'b0;
        count     = 10'd0;
        recv_busy = 1'b0;
        rdy_mode  = 1'b0;

        e2 = '{16'hA55A, 16'h0002, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
        if (CSUM) e2.push_back(16'h000A);
        e0 = '{16'hA55A, 16'h0000};
        if (CSUM) e0.push_back(16'h0000);

        #120;
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_txd", 32'(tx_data), 32'd0);
        chk("rst_vld", 32'(tx_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Two words, ready always high.
        run_frame(10'd2, 200, 0, base, cyc0);
        cmp_words("f2", base, e2);
        chk("f2_addr", 32'(addr), 32'd1);

        // Same frame with ready toggling every cycle.
        rdy_mode = 1'b1;
        run_frame(10'd2, 400, 0, base, cyc1);
        cmp_words("f2t", base, e2);
        rdy_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Empty frame: no address issued.
        a0   = int'(addr);
        chg0 = addr_chg;
        run_frame(10'd0, 200, 0, base, cyc1);
        cmp_words("f0", base, e0);
        chk("f0_addr", 32'(addr), 32'(a0));
        chk("f0_chg", 32'(addr_chg - chg0), 32'd0);

        // START while capture busy is ignored.
        base      = got_q.size();
        recv_busy = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        count = 10'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rb_busy", 32'(busy), 32'd0);
        chk("rb_words", 32'(got_q.size() - base), 32'd0);
        recv_busy = 1'b0;

        // Second START and RECV_BUSY change mid-frame have no effect.
        run_frame(10'd2, 200, 3, base, cyc2);
        cmp_words("f2p", base, e2);
        chk("f2p_cycles", 32'(cyc2), 32'(cyc0));

        // Oversized count clamps to 512 words.
        chg0 = addr_chg;
        eb   = '{16'hA55A, 16'h0200};
        for (int i = 0; i < 512; i++) begin
            eb.push_back(16'(2 * i + 1));
            eb.push_back(16'(2 * i + 2));
        end
        if (CSUM) eb.push_back(16'h0200);
        run_frame(10'd1000, 6000, 0, base, cyc1);
        chk("big_len", 32'(got_q.size() - base), CSUM ? 32'd1027 : 32'd1026);
        cmp_words("big", base, eb);
        chk("big_amax", 32'(addr_max), 32'd511);
        chk("big_seq", 32'(seq_err), 32'd0);
        chk("big_chg", 32'(addr_chg - chg0), 32'd512);

        // Reset mid-frame after three transfers.
        base = got_q.size();
        d0   = done_cnt;
        @(posedge clk); #1;
        start = 1'b1;
        count = 10'd2;
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        while (got_q.size() - base < 3 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("rst_seen3", 32'(got_q.size() - base >= 3), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_vld", 32'(tx_valid), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_nodone", 32'(done_cnt - d0), 32'd0);
        run_frame(10'd2, 200, 0, base, cyc1);
        cmp_words("post", base, e2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_reader.md
FRAME_READER -- requirements
Module: frame_reader

Interface
REQ-001 Parameter HEADER, default 16'hA55A, meaning first word of every output frame.
REQ-002 Parameter MAX_WORDS, default 512, meaning capture RAM depth in 32-bit words.
REQ-003 CLOCK_10M  input  1  sole clock; all logic on its rising edge.
REQ-004 RESET_N  input  1  reset, asynchronous, active-low.
REQ-005 START  input  1  frame request, single-cycle pulse.
REQ-006 COUNT  input  10  number of 32-bit words to read, sampled with START.
REQ-007 RECV_BUSY  input  1  capture stage still writing RAM.
REQ-008 ADDR  output  10  registered RAM read address.
REQ-009 RD_DATA  input  32  RAM read data, updated on the edge after ADDR is sampled.
REQ-010 TX_DATA  output  16  stream word.
REQ-011 TX_VALID  output  1  TX_DATA holds a valid word.
REQ-012 TX_READY  input  1  consumer accepts the word.
REQ-013 BUSY  output  1  frame in progress.
REQ-014 DONE  output  1  one-cycle pulse after the last word transfers.

Function
REQ-015 A transfer SHALL occur on each rising edge where TX_VALID and TX_READY are both high.
REQ-016 While TX_VALID is high and TX_READY is low, TX_DATA and TX_VALID SHALL remain unchanged.
REQ-017 START SHALL be accepted only in IDLE with RECV_BUSY low; otherwise it SHALL be ignored with no output change.
REQ-018 On acceptance, COUNT SHALL be latched; values above MAX_WORDS SHALL be clamped to MAX_WORDS. BUSY SHALL go high on the next edge.
REQ-019 Frame order: HEADER, latched count (zero-extended to 16 bits), then for each word n=0..N-1 RD_DATA[15:0] then RD_DATA[31:16], then the checksum word if enabled.
REQ-020 States: IDLE -> HDR -> CNT -> FETCH -> WAIT -> LO -> HI -> (FETCH if words remain, else SUM or FINISH) -> FINISH -> IDLE.
REQ-021 FETCH SHALL drive ADDR=n. RD_DATA SHALL be captured into a holding register exactly two edges after ADDR changes, covering the one-cycle RAM latency.
REQ-022 The checksum SHALL be the 16-bit modulo-2^16 sum of all data halfwords in the frame. HEADER and the count word SHALL be excluded.
REQ-023 With count 0, the frame SHALL be HEADER, 0, and the checksum word 0 if enabled. No RAM address SHALL be issued.
REQ-024 FINISH SHALL pulse DONE for one cycle, then clear BUSY and return to IDLE.
REQ-025 START during BUSY SHALL be ignored. A change in RECV_BUSY mid-frame SHALL NOT affect the frame.
REQ-026 ADDR SHALL hold its last value between frames.

Reset
REQ-027 RESET_N low SHALL immediately force IDLE, with ADDR=0, TX_DATA=0, TX_VALID=0, BUSY=0, DONE=0, checksum=0, and latched count=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame. No DONE SHALL be produced. The first frame after release SHALL start fresh from HEADER.

Configuration
REQ-029 Macro FRAME_READER_CHECKSUM_EN: when defined, the checksum word SHALL be appended after the last data word and the SUM state SHALL exist.
REQ-030 When FRAME_READER_CHECKSUM_EN is undefined, the frame SHALL end after the last data halfword, no checksum logic SHALL be built, and HI SHALL go directly to FINISH.

Verification
REQ-031 RAM[0]=32'h0002_0001, RAM[1]=32'h0004_0003, COUNT=2, TX_READY=1 -> stream A55A, 0002, 0001, 0002, 0003, 0004, 000A; DONE pulses once.
REQ-032 Same setup with TX_READY toggled 1-0-1 per cycle -> identical stream; TX_DATA stable during every low-ready cycle.
REQ-033 COUNT=0 -> A55A, 0000, 0000 (checksum on); no ADDR change.
REQ-034 COUNT=1000 -> count word 0200; ADDR runs 0..511; 1027 words transfer (checksum on).
REQ-035 START with RECV_BUSY=1, and a second START while BUSY -> both ignored; BUSY timing unchanged.
REQ-036 RESET_N pulsed low after 3 transfers -> TX_VALID=0 and BUSY=0 immediately; no DONE; next START yields a complete frame starting A55A.
